// File: rtl/cpu_phase_sequencer.sv
// Phase sequencer for the single-issue RISC-V core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the per-phase enables.
module cpu_phase_sequencer #(
   parameter int unsigned EXEC_CYCLES = 2,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run_mode,
   input  logic                 step_pulse,
   input  logic                 io_wait_req,
   input  logic                 io_ack,
   input  logic                 halt_req,
   input  logic                 resume,
   output logic                 fetch_en,
   output logic                 mem_en,
   output logic                 mem_commit,
   output logic                 reg_we_en,
   output logic                 pc_en,
   output logic                 io_waiting,
   output logic                 halted,
   output logic [2:0]           state_o,
   output logic [CNT_WIDTH-1:0] instret,
   output logic [CNT_WIDTH-1:0] stall_cnt
);

   typedef enum logic [2:0] {
      S_PAUSE  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

   state_e               state_q, state_d;
   logic [3:0]           exec_cnt_q, exec_cnt_d;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic                 mem_stall;

   // A MEM cycle stalls only while the switch read is still unconfirmed.
   assign mem_stall = (state_q == S_MEM) && io_wait_req && !io_ack;

   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_d     = state_q;
      exec_cnt_d  = '0;
      instret_d   = instret_q;
      stall_cnt_d = stall_cnt_q;
      unique case (state_q)
         S_PAUSE:  if (run_mode || step_pulse) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (exec_cnt_q == EXEC_LAST) state_d = S_MEM;
            else                         exec_cnt_d = exec_cnt_q + 4'd1;
         end
         S_MEM: begin
            if (mem_stall) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            else           state_d = S_WB;
         end
         S_WB: begin
            instret_d = instret_q + CNT_WIDTH'(1);
            if (halt_req)      state_d = S_HALT;
            else if (run_mode) state_d = S_FETCH;
            else               state_d = S_PAUSE;
         end
         S_HALT:   if (resume) state_d = run_mode ? S_FETCH : S_PAUSE;
         // Encoding 7 is unreachable in normal operation; fall back to PAUSE.
         default:  state_d = S_PAUSE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments and the asynchronous reset
   // clears every flop immediately, even mid-instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_PAUSE;
         exec_cnt_q  <= '0;
         instret_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         exec_cnt_q  <= exec_cnt_d;
         instret_q   <= instret_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_en   = (state_q == S_FETCH);
   assign mem_en     = (state_q == S_MEM);
   assign mem_commit = (state_q == S_MEM) && !mem_stall;
   assign io_waiting = mem_stall;
   assign reg_we_en  = (state_q == S_WB);
   assign pc_en      = (state_q == S_WB);
   assign halted     = (state_q == S_HALT);
   assign state_o    = state_q;
   assign instret    = instret_q;
   assign stall_cnt  = stall_cnt_q;

endmodule
